coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor.sv | 121 ++++++++++++
 tb/tb_coin_acceptor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronises and debounces two coin sensors, queues coin events
// in a small FIFO and presents them one at a time to the vending machine.
module coin_acceptor #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sense_half,
    input  logic       sense_one,
    input  logic       inhibit,
    output logic [1:0] coin,
    output logic       reject,
    output logic       overflow,
    output logic [2:0] pending
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]    CNT_LAST = 4'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    // Bit 0 carries the half-coin line, bit 1 the one-coin line.
    logic [1:0]      raw, sync1, sync2, deb, deb_d, rise;
    logic [1:0][3:0] cnt;

    logic [1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    state_t          state;

    logic            push, pop, full, push_ok;
    logic [1:0]      push_code;

    assign raw = {sense_one, sense_half};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= ~deb[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // A rise is visible for the single cycle after the debounced level goes high.
    assign rise      = deb & ~deb_d;
    assign push      = rise[0] ^ rise[1];
    assign push_code = rise[1] ? 2'b10 : 2'b01;
    assign full      = (count == DEPTH_C);
    assign pop       = (state != PRESENT) && (count != '0) && !inhibit;
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= IDLE;
            coin     <= 2'b00;
            reject   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            reject   <= rise[0] & rise[1];
            overflow <= push & full & ~pop;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
            case (state)
                IDLE, GAP: begin
                    if (pop) begin
                        state <= PRESENT;
                        coin  <= mem[rd_ptr];
                    end else begin
                        state <= IDLE;
                        coin  <= 2'b00;
                    end
                end
                PRESENT: begin
                    state <= GAP;
                    coin  <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    coin  <= 2'b00;
                end
            endcase
        end
    end

    assign pending = 3'(count);

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: directed scenarios plus a randomized sensor run
// checked against a window-based debounce and coin-scheduling reference model.
module tb_coin_acceptor;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int N     = 600;
    localparam int M     = N + 20;

    logic       clk;
    logic       rstn;
    logic       sense_half;
    logic       sense_one;
    logic       inhibit;
    logic [1:0] coin;
    logic       reject;
    logic       overflow;
    logic [2:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    bit         rr       [0:1][0:M];
    logic [1:0] exp_coin [0:M+8];
    bit         exp_rej  [0:M+8];
    int         exp_pend [0:M+8];
    int         push_at  [0:M+8];
    int         pop_at   [0:M+8];

    coin_acceptor #(.DEBOUNCE_CYC(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .sense_half(sense_half), .sense_one(sense_one),
        .inhibit(inhibit), .coin(coin), .reject(reject), .overflow(overflow),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rstn = 1'b0;
        sense_half = 1'b0;
        sense_one = 1'b0;
        inhibit = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        sense_half = 1'b0;
        sense_one = 1'b0;
        inhibit = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (coin !== 2'b00) begin n_bad++; $display("[TB] FAIL reset.coin got %b expected 00", coin); end
        n_cmp++;
        if (reject !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.reject got %b expected 0", reject); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.overflow got %b expected 0", overflow); end
        n_cmp++;
        if (pending !== 3'd0) begin n_bad++; $display("[TB] FAIL reset.pending got %0d expected 0", pending); end
    endtask

    task automatic test_single_coin;
        logic [1:0] ec;
        logic [2:0] ep;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            sense_one = (k <= 20);
            step();
            ec = (k == 8) ? 2'b10 : 2'b00;
            ep = (k == 7) ? 3'd1 : 3'd0;
            n_cmp++;
            if (coin !== ec) begin n_bad++; $display("[TB] FAIL single.coin edge %0d got %b expected %b", k, coin, ec); end
            n_cmp++;
            if (pending !== ep) begin n_bad++; $display("[TB] FAIL single.pending edge %0d got %0d expected %0d", k, pending, ep); end
        end
    endtask

    task automatic test_bounce;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            sense_half = (k == 1 || k == 3);
            step();
            n_cmp++;
            if (coin !== 2'b00 || reject !== 1'b0 || overflow !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL bounce edge %0d got coin=%b reject=%b overflow=%b expected 00/0/0", k, coin, reject, overflow);
            end
        end
    endtask

    task automatic test_four_half;
        logic [1:0] ec;
        do_reset();
        for (int k = 1; k <= 90; k++) begin
            sense_half = ((k - 1) % 20 < 10) && ((k - 1) / 20 < 4);
            step();
            ec = (k >= 8 && (k - 8) % 20 == 0 && (k - 8) / 20 < 4) ? 2'b01 : 2'b00;
            n_cmp++;
            if (coin !== ec) begin n_bad++; $display("[TB] FAIL four_half.coin edge %0d got %b expected %b", k, coin, ec); end
        end
    endtask

    task automatic test_simultaneous;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            sense_half = (k <= 10);
            sense_one = (k <= 10);
            step();
            n_cmp++;
            if (reject !== (k == 7)) begin n_bad++; $display("[TB] FAIL simul.reject edge %0d got %b expected %b", k, reject, (k == 7)); end
            n_cmp++;
            if (coin !== 2'b00 || pending !== 3'd0) begin
                n_bad++;
                $display("[TB] FAIL simul.coin_pending edge %0d got %b/%0d expected 00/0", k, coin, pending);
            end
        end
    endtask

    task automatic test_overflow;
        logic [1:0] codes [5];
        logic [1:0] ec;
        int         ep;
        codes[0] = 2'b01; codes[1] = 2'b10; codes[2] = 2'b01; codes[3] = 2'b01; codes[4] = 2'b10;
        do_reset();
        inhibit = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            int i;
            int ph;
            i = (k - 1) / 20;
            ph = (k - 1) % 20;
            sense_half = (i < 5) && (ph < 10) && (codes[i % 5] == 2'b01);
            sense_one = (i < 5) && (ph < 10) && (codes[i % 5] == 2'b10);
            step();
            ep = 0;
            for (int j = 0; j < 5; j++) if (20 * j + 7 <= k) ep++;
            if (ep > DEPTH) ep = DEPTH;
            n_cmp++;
            if (overflow !== (k == 87)) begin n_bad++; $display("[TB] FAIL ovf.overflow edge %0d got %b expected %b", k, overflow, (k == 87)); end
            n_cmp++;
            if (pending !== 3'(ep)) begin n_bad++; $display("[TB] FAIL ovf.pending edge %0d got %0d expected %0d", k, pending, ep); end
            n_cmp++;
            if (coin !== 2'b00) begin n_bad++; $display("[TB] FAIL ovf.inhibited_coin edge %0d got %b expected 00", k, coin); end
        end
        inhibit = 1'b0;
        for (int k = 101; k <= 115; k++) begin
            step();
            ec = 2'b00;
            if (k == 101 || k == 103 || k == 105 || k == 107) ec = codes[(k - 101) / 2];
            ep = 4;
            for (int j = 101; j <= 107; j += 2) if (j <= k) ep--;
            n_cmp++;
            if (coin !== ec) begin n_bad++; $display("[TB] FAIL ovf.drain_coin edge %0d got %b expected %b", k, coin, ec); end
            n_cmp++;
            if (pending !== 3'(ep)) begin n_bad++; $display("[TB] FAIL ovf.drain_pending edge %0d got %0d expected %0d", k, pending, ep); end
        end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        inhibit = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            sense_half = ((k - 1) % 20 < 10);
            step();
        end
        inhibit = 1'b0;
        step();
        n_cmp++;
        if (coin !== 2'b01 || pending !== 3'd2) begin
            n_bad++;
            $display("[TB] FAIL midreset.before got %b/%0d expected 01/2", coin, pending);
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (coin !== 2'b00 || pending !== 3'd0) begin
            n_bad++;
            $display("[TB] FAIL midreset.async got %b/%0d expected 00/0", coin, pending);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            n_cmp++;
            if (coin !== 2'b00 || pending !== 3'd0) begin
                n_bad++;
                $display("[TB] FAIL midreset.after edge %0d got %b/%0d expected 00/0", k, coin, pending);
            end
        end
    endtask

    task automatic test_held_through_reset;
        logic [1:0] ec;
        do_reset();
        sense_half = 1'b1;
        repeat (12) step();
        rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            ec = (k == 8) ? 2'b01 : 2'b00;
            n_cmp++;
            if (coin !== ec) begin n_bad++; $display("[TB] FAIL held_reset.coin edge %0d got %b expected %b", k, coin, ec); end
        end
    endtask

    task automatic test_random;
        bit a, b, v, all_diff;
        bit lvl  [2];
        bit rise [2];
        int k, len, mode, idx, p, c, last_c, occ;
        for (int e = 0; e <= M; e++) begin
            rr[0][e] = 1'b0;
            rr[1][e] = 1'b0;
        end
        for (int e = 0; e <= M + 8; e++) begin
            exp_coin[e] = 2'b00;
            exp_rej[e] = 1'b0;
            push_at[e] = 0;
            pop_at[e] = 0;
        end
        k = 1;
        while (k <= N) begin
            len = int'($urandom_range(1, 12));
            mode = int'($urandom_range(0, 3));
            a = 1'($urandom_range(0, 1));
            b = (mode == 0) ? a : 1'($urandom_range(0, 1));
            for (int j = 0; j < len && k <= N; j++) begin
                rr[0][k] = a;
                rr[1][k] = b;
                k++;
            end
        end
        // A level flips once the last DEB synchronised samples all disagree with it.
        lvl[0] = 1'b0;
        lvl[1] = 1'b0;
        last_c = -10;
        for (int e = 1; e <= M; e++) begin
            for (int l = 0; l < 2; l++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= DEB + 1; j++) begin
                    idx = e - j;
                    v = (idx >= 1) ? rr[l][idx] : 1'b0;
                    if (v == lvl[l]) all_diff = 1'b0;
                end
                rise[l] = 1'b0;
                if (all_diff) begin
                    lvl[l] = ~lvl[l];
                    rise[l] = lvl[l];
                end
            end
            if (rise[0] && rise[1]) begin
                exp_rej[e + 1] = 1'b1;
            end else if (rise[0] || rise[1]) begin
                p = e + 1;
                c = (p + 1 > last_c + 2) ? p + 1 : last_c + 2;
                if (c <= M + 8) begin
                    push_at[p]++;
                    pop_at[c]++;
                    exp_coin[c] = rise[1] ? 2'b10 : 2'b01;
                end
                last_c = c;
            end
        end
        occ = 0;
        for (int e = 1; e <= M; e++) begin
            occ += push_at[e] - pop_at[e];
            exp_pend[e] = occ;
        end
        do_reset();
        for (int e = 1; e <= M; e++) begin
            sense_half = rr[0][e];
            sense_one = rr[1][e];
            step();
            n_cmp++;
            if (coin !== exp_coin[e]) begin n_bad++; $display("[TB] FAIL random.coin edge %0d got %b expected %b", e, coin, exp_coin[e]); end
            n_cmp++;
            if (reject !== exp_rej[e]) begin n_bad++; $display("[TB] FAIL random.reject edge %0d got %b expected %b", e, reject, exp_rej[e]); end
            n_cmp++;
            if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL random.overflow edge %0d got %b expected 0", e, overflow); end
            n_cmp++;
            if (pending !== 3'(exp_pend[e])) begin n_bad++; $display("[TB] FAIL random.pending edge %0d got %0d expected %0d", e, pending, exp_pend[e]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_coin();
        test_bounce();
        test_four_half();
        test_simultaneous();
        test_overflow();
        test_reset_midstream();
        test_held_through_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
